// File: rtl/div_iter_pkg.sv
// Shared encodings for the iterative divider: FSM states, handshake levels
// and the ALU op codes the decoder uses to steer DIV/DIVU here.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // EX stalls while a divide is in flight; END is not busy because the result is already valid.
    function automatic logic div_is_busy(input div_state_e state);
        return (state == DivByZero) || (state == DivOn);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the {partial remainder, quotient}
// working register left and keep the trial subtraction only if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  work_i,
    input  logic [WIDTH-1:0]  divisor_i,
    output logic [2*WIDTH:0]  work_o
);

    logic [2*WIDTH:0] shifted_s;
    logic [WIDTH:0]   hi_s;
    logic [WIDTH:0]   diff_s;
    logic             fits_s;
    // The top bit is always zero between steps (remainder < divisor), so it is shifted out unused.
    logic             unused_msb_s;

    assign unused_msb_s = work_i[2*WIDTH];

    // Trial subtract of the divisor from the shifted partial remainder.
    always_comb begin
        shifted_s = {work_i[2*WIDTH-1:0], 1'b0};
        hi_s      = shifted_s[2*WIDTH:WIDTH];
        fits_s    = (hi_s >= {1'b0, divisor_i});
        diff_s    = hi_s - {1'b0, divisor_i};
        if (fits_s) begin
            work_o = {diff_s, shifted_s[WIDTH-1:1], 1'b1};
        end else begin
            work_o = shifted_s;
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: WIDTH cycles per divide,
// result {remainder, quotient} held until EX drops start_i.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    div_state_e           state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH:0]     work_q,    work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 sign1_q,   sign1_d;
    logic                 sign2_q,   sign2_d;
    logic                 signed_q,  signed_d;
    logic [2*WIDTH-1:0]   result_q,  result_d;
    logic                 ready_q,   ready_d;

    logic [2*WIDTH:0]     step_s;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic [WIDTH-1:0]     op1_abs_s;
    logic [WIDTH-1:0]     op2_abs_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] value);
        return ~value + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (step_s)
    );

    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign op1_abs_s = (signed_div_i && opdata1_i[WIDTH-1]) ? neg_w(opdata1_i) : opdata1_i;
    assign op2_abs_s = (signed_div_i && opdata2_i[WIDTH-1]) ? neg_w(opdata2_i) : opdata2_i;
    // Sign fix-up is applied to the final step's output so the result registers on the last edge.
    assign quo_fix_s = (signed_q && (sign1_q ^ sign2_q)) ? neg_w(step_s[WIDTH-1:0]) : step_s[WIDTH-1:0];
    assign rem_fix_s = (signed_q && sign1_q) ? neg_w(step_s[2*WIDTH-1:WIDTH]) : step_s[2*WIDTH-1:WIDTH];

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = div_is_busy(state_q);

    // Next-state, datapath and output decode for the divide sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        signed_d  = signed_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = {(2*WIDTH){1'b0}};
                if ((start_i == DivStart) && !annul_i) begin
                    if (opdata2_i == {WIDTH{1'b0}}) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        work_d    = {{(WIDTH+1){1'b0}}, op1_abs_s};
                        divisor_d = op2_abs_s;
                        sign1_d   = opdata1_i[WIDTH-1];
                        sign2_d   = opdata2_i[WIDTH-1];
                        signed_d  = signed_div_i;
                        cnt_d     = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = DivFree;
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    state_d  = DivEnd;
                    result_d = {(2*WIDTH){1'b0}};
                    ready_d  = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = {(2*WIDTH){1'b0}};
                end else begin
                    work_d = step_s;
                    cnt_d  = cnt_inc_s;
                    if (cnt_inc_s == CNT_W'(WIDTH)) begin
                        state_d  = DivEnd;
                        result_d = {rem_fix_s, quo_fix_s};
                        ready_d  = DivResultReady;
                    end else begin
                        state_d = DivOn;
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = {(2*WIDTH){1'b0}};
                end else begin
                    state_d = DivEnd;
                end
            end
            default: begin
                state_d  = DivFree;
                ready_d  = DivResultNotReady;
                result_d = {(2*WIDTH){1'b0}};
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= {CNT_W{1'b0}};
            work_q    <= {(2*WIDTH+1){1'b0}};
            divisor_q <= {WIDTH{1'b0}};
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            signed_q  <= 1'b0;
            result_q  <= {(2*WIDTH){1'b0}};
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            signed_q  <= signed_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (WIDTH=32): directed cases plus randomized
// divides compared each cycle against a timeline/arithmetic reference model.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    div_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic: {remainder, quotient}; zero divisor yields 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Timeline model: a divide accepted in cycle k delivers its result in cycle k+33 (k+2 for zero divisor).
    logic        m_pend, m_done;
    int          m_due;
    logic [63:0] m_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend <= 1'b0;
            m_done <= 1'b0;
            m_due  <= 0;
            m_res  <= 64'd0;
        end else if (m_done) begin
            if (!start_i) m_done <= 1'b0;
        end else if (m_pend) begin
            if (annul_i) m_pend <= 1'b0;
            else if (cyc == m_due - 1) begin
                m_pend <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (start_i && !annul_i) begin
            m_pend <= 1'b1;
            m_due  <= cyc + ((opdata2_i == 32'd0) ? 2 : 33);
            m_res  <= ref_div(opdata1_i, opdata2_i, signed_div_i);
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        total = total + 3;
        if (busy_o !== m_pend) begin
            bad = bad + 1;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy_o, m_pend);
        end
        if (ready_o !== m_done) begin
            bad = bad + 1;
            $display("FAIL ready cyc=%0d got=%b want=%b", cyc, ready_o, m_done);
        end
        if (result_o !== (m_done ? m_res : 64'd0)) begin
            bad = bad + 1;
            $display("FAIL result cyc=%0d got=%h want=%h", cyc, result_o, (m_done ? m_res : 64'd0));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic scramble();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
    endtask

    // Directed divide: checks latency and result literally, holds start, then checks the clear.
    task automatic run_dir(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] want, input int want_lat, input int hold);
        int k, n;
        start_i = 1'b1; opdata1_i = a; opdata2_i = b; signed_div_i = s;
        k = cyc;
        n = 0;
        do begin
            tick();
            scramble();
            n++;
        end while (!ready_o && n < 80);
        check64({name, "_lat"}, 64'(cyc - k), 64'(want_lat));
        check64({name, "_res"}, result_o, want);
        for (int h = 0; h < hold; h++) tick();
        check64({name, "_hold"}, {63'd0, ready_o}, 64'd1);
        start_i = 1'b0;
        tick();
        check64({name, "_clr"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    task automatic run_rand(input int annul_at, input int hold);
        int n;
        logic fin;
        start_i = 1'b1;
        opdata1_i = pick_op();
        opdata2_i = pick_op();
        signed_div_i = 1'($urandom_range(0, 1));
        n = 0;
        fin = 1'b0;
        while (!fin) begin
            tick();
            n++;
            scramble();
            if (annul_at != 0 && n == annul_at) annul_i = 1'b1;
            else if (annul_at != 0 && n == annul_at + 1) begin
                annul_i = 1'b0; start_i = 1'b0; fin = 1'b1;
            end else if (ready_o) begin
                for (int h = 0; h < hold; h++) tick();
                start_i = 1'b0; fin = 1'b1;
            end else if (n > 80) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL rand_timeout got=no_ready want=ready");
                start_i = 1'b0; fin = 1'b1;
            end
        end
        tick();
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        #2;
        check64("reset_out", {result_o[61:0], ready_o, busy_o}, 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Pin the reference arithmetic itself.
        check64("ref_u", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        check64("ref_s", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        run_dir("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 0);
        run_dir("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        run_dir("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
        run_dir("byzero", 32'h1234_5678, 32'd0, 1'b0, 64'd0, 2, 0);
        run_dir("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, 5);

        // Annul mid-divide, then restart.
        start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
        k = cyc;
        while (cyc < k + 10) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0; start_i = 1'b0;
        check64("annul_free", {62'd0, busy_o, ready_o}, 64'd0);
        tick();
        run_dir("after_annul", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 33, 0);

        // Asynchronous reset between edges mid-divide.
        start_i = 1'b1; opdata1_i = 32'd5000; opdata2_i = 32'd7; signed_div_i = 1'b0;
        k = cyc;
        while (cyc < k + 15) tick();
        #2;
        rst = 1'b0;
        #1;
        check64("async_rst", {result_o[61:0], ready_o, busy_o}, 64'd0);
        start_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        run_dir("u9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0);

        for (int t = 0; t < 40; t++) begin
            run_rand(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0,
                     int'($urandom_range(0, 3)));
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
